// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Valid/ready on both sides; a zero divisor short-circuits straight to a flagged result.
module seq_restoring_divider #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           dbz
);

   localparam int unsigned CntW = (2 * N > 1) ? $clog2(2 * N) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StHold
   } state_e;

   state_e           state_q;
   logic [2*N-1:0]   q_q;
   logic [N-1:0]     r_q;
   logic [N-1:0]     div_q;
   logic [CntW-1:0]  cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [2*N-1:0]   quotient_q;
   logic [N-1:0]     remainder_q;
   logic             dbz_q;

   logic [N:0]       trial;
   logic [N:0]       diff;
   logic             ge;
   logic [N-1:0]     r_d;
   logic [2*N-1:0]   q_d;
   logic             last_step;

   // One restoring step: shift the next dividend bit into the partial remainder and subtract
   // the divisor when it fits. R < divisor always holds, so the trial fits N+1 bits.
   always_comb begin
      trial     = {r_q, q_q[2*N-1]};
      diff      = trial - {1'b0, div_q};
      ge        = (trial >= {1'b0, div_q});
      r_d       = ge ? diff[N-1:0] : trial[N-1:0];
      q_d       = {q_q[2*N-2:0], ge};
      last_step = (cnt_q == CntW'(2 * N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         q_q         <= '0;
         r_q         <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (divisor != '0) begin
                     div_q   <= divisor;
                     q_q     <= dividend;
                     r_q     <= '0;
                     cnt_q   <= '0;
                     state_q <= StCalc;
                  end else begin
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= StHold;
                  end
               end
            end
            StCalc: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + CntW'(1);
               if (last_step) begin
                  quotient_q  <= q_d;
                  remainder_q <= r_d;
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StHold;
               end
            end
            StHold: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign dbz       = dbz_q;

endmodule
